mw_add_seq: RTL and testbench
=============================

MW_ADD_SEQ -- requirements
Module: mw_add_seq

Interface
REQ-001 The block SHALL have parameter WORDS, default 4, giving the number of 16-bit chunks per operand; legal values are 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, 16*WORDS bits: operand A.
REQ-007 The block SHALL have port b, input, 16*WORDS bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry into chunk 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The block SHALL have port sum, output, 16*WORDS bits: result of a+b+cin, modulo 2^(16*WORDS).
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the top chunk.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the full-width add.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 A handshake SHALL occur when in_valid and in_ready are both 1 at a clock edge; the block then latches a, b and cin, clears the chunk counter, and enters RUN.
REQ-017 The block SHALL ignore input changes after the handshake; the latched operands are authoritative.
REQ-018 In RUN, each cycle SHALL present chunk[cnt] of the latched A and B to one 16-bit carry-select adder, with the carry register as its cin.
REQ-019 At each RUN edge, the block SHALL write the adder sum into sum[16*cnt +: 16], load the carry register with the adder cout, and increment cnt.
REQ-020 The carry register SHALL be loaded with cin at the handshake, so chunk 0 uses cin.
REQ-021 After the RUN edge with cnt == WORDS-1, the FSM SHALL enter DONE, out_valid SHALL become 1, and cout SHALL equal the final carry.
REQ-022 Latency SHALL be exactly WORDS cycles from the handshake edge to the edge after which out_valid is 1 (4 cycles at default).
REQ-023 ovf SHALL equal (A_msb == B_msb) && (sum_msb != A_msb), using the latched operands; it is valid whenever out_valid is 1.
REQ-024 In DONE, sum, cout and ovf SHALL hold stable until out_valid and out_ready are both 1 at an edge; the FSM then returns to IDLE.
REQ-025 out_valid SHALL fall in the cycle after the output handshake; a new input is accepted no earlier than the edge after that (no same-edge overlap).
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 sum, cout and ovf SHALL keep their last values in IDLE; their values during RUN are don't-care to the consumer, though sum updates chunk by chunk.
REQ-028 The chunk counter SHALL be ceil(log2(WORDS)) bits wide and SHALL never exceed WORDS-1.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously force: FSM to IDLE, cnt = 0, carry register = 0, sum = 0, cout = 0, ovf = 0, out_valid = 0.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered.
REQ-032 After rst_n is released, the first rising edge SHALL be able to perform a handshake.

Structure
REQ-033 The shared package mw_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant CHUNK_W = 16.
REQ-034 The block SHALL contain exactly one sub-module: the team's existing 16-bit cs_adder (ports A, B, cin, sum, cout), instantiated once and time-multiplexed across chunks.

Verification
REQ-035 The bench SHALL cover a basic add: a=64'h0aa0, b=64'h0ff2, cin=0 -> sum=64'h1a92, cout=0, ovf=0, with out_valid exactly 4 cycles after the handshake.
REQ-036 The bench SHALL cover carry chaining across chunks: a=64'h0000_0000_0000_ffff, b=64'h1, cin=0 -> sum=64'h0000_0000_0001_0000, cout=0.
REQ-037 The bench SHALL cover full wrap: a=64'hffff_ffff_ffff_ffff, b=0, cin=1 -> sum=0, cout=1, ovf=0.
REQ-038 The bench SHALL cover signed overflow: a=64'h7fff_ffff_ffff_ffff, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
REQ-039 The bench SHALL cover backpressure: out_ready=0 for 3 cycles in DONE -> sum, cout, ovf and out_valid stable, in_ready=0, and in_valid pulses ignored; raising out_ready -> IDLE on the next edge.
REQ-040 The bench SHALL cover reset in RUN: rst_n low at cnt=2 -> all outputs 0 immediately, in_ready=1 after release, and a following add of 64'h0400 + 64'h00f2 + 1 gives 64'h04f3.

Source files
------------

// File: rtl/mw_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mw_add_pkg
//  Purpose  : Shared types and constants for the multi-word sequential adder.
//  Revision : 1.0  initial release
// ============================================================================
package mw_add_pkg;

  // Width of one adder chunk; the datapath is time-multiplexed at this width.
  localparam int CHUNK_W = 16;

  // Controller states of the multi-word adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mw_add_seq_cs_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cs_adder
//  Purpose  : 16-bit carry-select adder. The low half ripples from cin; the
//             high half is precomputed for both carry values and selected by
//             the low-half carry.
//  Revision : 1.0  initial release
// ============================================================================
module cs_adder
  import mw_add_pkg::*;
(
  input  logic [CHUNK_W-1:0] A,
  input  logic [CHUNK_W-1:0] B,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  localparam int HALF_W = CHUNK_W / 2;

  logic [HALF_W:0] lo_res;
  logic [HALF_W:0] hi_res0;
  logic [HALF_W:0] hi_res1;

  // Low half, carry in from the chunk input.
  assign lo_res  = {1'b0, A[HALF_W-1:0]} + {1'b0, B[HALF_W-1:0]} + {{HALF_W{1'b0}}, cin};
  // High half computed speculatively for carry-in 0 and 1.
  assign hi_res0 = {1'b0, A[CHUNK_W-1:HALF_W]} + {1'b0, B[CHUNK_W-1:HALF_W]};
  assign hi_res1 = {1'b0, A[CHUNK_W-1:HALF_W]} + {1'b0, B[CHUNK_W-1:HALF_W]} + {{HALF_W{1'b0}}, 1'b1};

  // Select the high half according to the low-half carry.
  always_comb begin
    sum[HALF_W-1:0] = lo_res[HALF_W-1:0];
    if (lo_res[HALF_W]) begin
      sum[CHUNK_W-1:HALF_W] = hi_res1[HALF_W-1:0];
      cout                  = hi_res1[HALF_W];
    end else begin
      sum[CHUNK_W-1:HALF_W] = hi_res0[HALF_W-1:0];
      cout                  = hi_res0[HALF_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mw_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mw_add_seq
//  Purpose  : Sequential multi-word adder. Latches two WORDS*16-bit operands
//             and a carry-in, then adds one 16-bit chunk per cycle through a
//             single shared carry-select adder, reporting sum, carry-out and
//             signed overflow through a valid/ready result port.
//  Revision : 1.0  initial release
// ============================================================================
module mw_add_seq
  import mw_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHUNK_W*WORDS-1:0] a,
  input  logic [CHUNK_W*WORDS-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHUNK_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int                W        = CHUNK_W * WORDS;
  localparam int                CNT_W    = $clog2(WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [W-1:0]        a_lat;
  logic [W-1:0]        b_lat;
  logic                carry;
  logic                accept;
  logic                last;

  logic [CHUNK_W-1:0]  add_a;
  logic [CHUNK_W-1:0]  add_b;
  logic [CHUNK_W-1:0]  add_sum;
  logic                add_cout;

  // Chunk selection: route latched chunk[cnt] of each operand to the adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (cnt == CNT_W'(i)) begin
        add_a = a_lat[i*CHUNK_W +: CHUNK_W];
        add_b = b_lat[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  cs_adder u_cs_adder (
    .A    (add_a),
    .B    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; out_ready only matters in DONE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture at the handshake, one chunk per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat <= '0;
      b_lat <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_lat <= a;
      b_lat <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < WORDS; i++) begin
        if (cnt == CNT_W'(i)) begin
          sum[i*CHUNK_W +: CHUNK_W] <= add_sum;
        end
      end
      carry <= add_cout;
      if (last) begin
        // Final chunk: publish carry-out and signed overflow; park the
        // counter at zero so it never runs past the top chunk.
        cout <= add_cout;
        ovf  <= (a_lat[W-1] == b_lat[W-1]) && (add_sum[CHUNK_W-1] != a_lat[W-1]);
        cnt  <= '0;
      end else begin
        cnt  <= cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mw_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mw_add_seq
//  Purpose  : Self-checking bench for mw_add_seq (WORDS = 4) with a
//             scoreboard queue of expected results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mw_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];

  mw_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: full-width add with carry and two's-complement overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t       e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // Present operands at a negedge, handshake on the next posedge, then scramble inputs.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a        = x;
    b        = y;
    cin      = ci;
    in_valid = 1'b1;
    sb.push_back(model(x, y, ci));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    cin      = 1'($urandom);
  endtask

  // Count edges after the handshake until out_valid is seen (bounded).
  task automatic wait_result(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (sum !== '0)         begin n_fail++; $display("FAIL reset_sum got %h exp 0", sum); end
    n_cmp++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout got %b exp 0", cout); end
    n_cmp++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    exp_t         e;
    bit           ok;
    int           lat;
    va = '{64'h0aa0, 64'h0000_0000_0000_ffff, 64'hffff_ffff_ffff_ffff, 64'h7fff_ffff_ffff_ffff};
    vb = '{64'h0ff2, 64'h1,                   64'h0,                   64'h1};
    vc = '{1'b0,     1'b0,                    1'b1,                    1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(va[k], vb[k], vc[k]);
      wait_result(ok, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("FAIL dir%0d_timeout got no out_valid exp out_valid within 50 cycles", k);
      end else begin
        n_cmp++; if (lat != WORDS)  begin n_fail++; $display("FAIL dir%0d_latency got %0d exp %0d", k, lat, WORDS); end
        n_cmp++; if (sum !== e.s)   begin n_fail++; $display("FAIL dir%0d_sum got %h exp %h", k, sum, e.s); end
        n_cmp++; if (cout !== e.c)  begin n_fail++; $display("FAIL dir%0d_cout got %b exp %b", k, cout, e.c); end
        n_cmp++; if (ovf !== e.o)   begin n_fail++; $display("FAIL dir%0d_ovf got %b exp %b", k, ovf, e.o); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++; $display("FAIL dir%0d_release got valid=%b ready=%b exp valid=0 ready=1", k, out_valid, in_ready);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    exp_t         e;
    bit           ok;
    int           lat;
    logic [W-1:0] x;
    logic [W-1:0] y;
    out_ready = 1'b1;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    for (int k = 0; k < N; k++) begin
      wait_result(ok, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("FAIL b2b%0d_timeout got no out_valid exp out_valid within 50 cycles", k);
      end else begin
        n_cmp++; if (lat != WORDS) begin n_fail++; $display("FAIL b2b%0d_latency got %0d exp %0d", k, lat, WORDS); end
        n_cmp++; if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
          n_fail++; $display("FAIL b2b%0d_result got %h/%b/%b exp %h/%b/%b", k, sum, cout, ovf, e.s, e.c, e.o);
        end
      end
      if (k < N - 1) begin
        // Offer the next operands while the result is still being consumed;
        // they must only be taken on the edge after out_valid falls.
        x = (k % 2 == 0) ? {$urandom, $urandom} : {1'b1, 31'($urandom), $urandom};
        y = (k % 2 == 0) ? {$urandom, $urandom} : {1'b1, 31'($urandom), $urandom};
        a        = x;
        b        = y;
        cin      = 1'(k);
        in_valid = 1'b1;
        sb.push_back(model(x, y, 1'(k)));
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b%0d_gap got valid=%b ready=%b exp valid=0 ready=1", k, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    int   lat;
    out_ready = 1'b0;
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_result(ok, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_timeout got no out_valid exp out_valid within 50 cycles");
    end else begin
      for (int k = 0; k < 3; k++) begin
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp%0d_hold_hs got valid=%b ready=%b exp valid=1 ready=0", k, out_valid, in_ready);
        end
        n_cmp++; if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
          n_fail++; $display("FAIL bp%0d_hold_data got %h/%b/%b exp %h/%b/%b", k, sum, cout, ovf, e.s, e.c, e.o);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
      end
      n_cmp++; if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
        n_fail++; $display("FAIL bp_idle_hold got %h/%b/%b exp %h/%b/%b", sum, cout, ovf, e.s, e.c, e.o);
      end
    end
  endtask

  task automatic test_reset_in_run();
    exp_t e;
    bit   ok;
    int   lat;
    out_ready = 1'b1;
    send(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL rr_clear got %h/%b/%b exp 0/0/0", sum, cout, ovf);
    end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rr_state got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_result got %b exp 0", out_valid); end
    rst_n = 1'b1;
    send(64'h0400, 64'h00f2, 1'b1);
    wait_result(ok, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL rr_timeout got no out_valid exp out_valid within 50 cycles");
    end else begin
      n_cmp++; if (lat != WORDS)          begin n_fail++; $display("FAIL rr_latency got %0d exp %0d", lat, WORDS); end
      n_cmp++; if (sum !== 64'h04f3)      begin n_fail++; $display("FAIL rr_sum got %h exp %h", sum, 64'h04f3); end
      n_cmp++; if (cout !== e.c || ovf !== e.o) begin
        n_fail++; $display("FAIL rr_flags got %b/%b exp %b/%b", cout, ovf, e.c, e.o);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_in_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
